// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - widths and FSM state type for mem_ctrl; SRAM_W grows by one under MEM_CTRL_PARITY_EN
package mem_ctrl_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
`ifdef MEM_CTRL_PARITY_EN
    localparam int SRAM_W = DATA_W + 1;
`else
    localparam int SRAM_W = DATA_W;
`endif
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mem_ctrl_state_e;
endpackage

// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - shared memory port between arbiter (master) and mem_ctrl (slave)
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_write;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              mem_parity_err;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_write,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_parity_err
    );
    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_write,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_parity_err
    );
endinterface

// File: rtl/mem_parity.sv
// rtl/mem_parity.sv - combinational even-parity bit over one data word
module mem_parity
    import mem_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    output logic              o_parity
);
    assign o_parity = ^i_data;
endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - one-at-a-time sequencer from the shared memory port to a fixed-latency sync SRAM
// Optional MEM_CTRL_PARITY_EN stores an even-parity bit alongside each word and flags mismatches on reads.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 0
)
(
    input  logic              clk,
    input  logic              resetN,
    mem_ctrl_if.slave         mem,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [SRAM_W-1:0] sram_wdata,
    input  logic [SRAM_W-1:0] sram_rdata
);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_RESP  = RESP;

    generate
        if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
            $error("mem_ctrl: RD_LAT must be 1..15");
        end
        if (WR_LAT < 0 || WR_LAT > 15) begin : g_bad_wr_lat
            $error("mem_ctrl: WR_LAT must be 0..15");
        end
    endgenerate

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_parity_err;
    logic              r_sram_cs;
    logic              r_sram_we;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [SRAM_W-1:0] r_sram_wdata;
    logic [SRAM_W-1:0] w_wdata_word;
    logic              w_rd_perr;

`ifdef MEM_CTRL_PARITY_EN
    logic w_wr_par;
    logic w_rd_par;
    mem_parity u_par_gen (.i_data(mem.mem_req_write),          .o_parity(w_wr_par));
    mem_parity u_par_chk (.i_data(sram_rdata[DATA_W-1:0]),     .o_parity(w_rd_par));
    assign w_wdata_word = {w_wr_par, mem.mem_req_write};
    assign w_rd_perr    = (w_rd_par != sram_rdata[DATA_W]);
`else
    assign w_wdata_word = mem.mem_req_write;
    assign w_rd_perr    = 1'b0;
`endif

    // The sram_* registers double as the request latch; only chip select pulses.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_resp_data  <= '0;
            r_parity_err <= 1'b0;
            r_sram_cs    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
        end else begin
            r_sram_cs <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem.mem_req_valid) begin
                        r_state      <= S_ISSUE;
                        r_sram_cs    <= 1'b1;
                        r_sram_we    <= mem.mem_req_we;
                        r_sram_addr  <= mem.mem_req_addr;
                        r_sram_wdata <= w_wdata_word;
                    end
                end
                S_ISSUE: begin
                    if (!r_sram_we) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 4'(RD_LAT - 1);
                    end else if (WR_LAT == 0) begin
                        r_state      <= S_RESP;
                        r_resp_data  <= '0;
                        r_parity_err <= 1'b0;
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= 4'(WR_LAT - 1);
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                        if (!r_sram_we) begin
                            r_resp_data  <= sram_rdata[DATA_W-1:0];
                            r_parity_err <= w_rd_perr;
                        end else begin
                            r_resp_data  <= '0;
                            r_parity_err <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem.mem_req_ready  = (r_state == S_IDLE) && resetN;
    assign mem.mem_resp_valid = (r_state == S_RESP);
    assign mem.mem_resp_data  = r_resp_data;
    assign mem.mem_parity_err = r_parity_err && (r_state == S_RESP);

    assign sram_cs    = r_sram_cs;
    assign sram_we    = r_sram_we;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;
endmodule
